// File: rtl/d_inst_queue.sv
// d_inst_queue: in-order instruction-return queue between the fetch request
// port and decode. Each accepted fetch request reserves an entry holding its
// pc. Returning instruction data fills entries in request order, and decode
// pops them from the head. A cancel flushes every queued entry. It also
// converts every still-outstanding response into a pending discard, which is
// tracked in drop_cnt_q.
//
// Handshakes:
//  - Decode side: valid_o/allowin_next. A pop happens in any cycle where
//    valid_o && allowin_next. valid_o never depends on allowin_next.
//  - Fetch side: allowin/req_fire. req_fire may only be asserted while
//    allowin=1. allowin depends on registered state only.
module d_inst_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_fire,
  input  logic [PC_W-1:0]          req_pc,
  output logic                     allowin,
  input  logic                     inst_data_ok,
  input  logic [DATA_W-1:0]        inst_rdata,
  input  logic                     cancel,
  output logic                     valid_o,
  output logic [PC_W-1:0]          pc_o,
  output logic [DATA_W-1:0]        inst_o,
  input  logic                     allowin_next,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW:0] DEPTH_V = (PW+1)'(DEPTH);

  // Pointers carry one extra wrap bit so that a full queue differs from an
  // empty one.
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] fill_q, fill_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW-1:0] drop_cnt_q, drop_cnt_d;

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  logic [PW-1:0] count;
  logic [PW-1:0] pending;
  logic [PW-1:0] ready;
  logic [PW:0]   occupancy;
  logic          resp_drop;
  logic          resp_fill;
  logic          resp_consumed;
  logic          hit;
  logic          pop;
  logic          push;
  logic          store_inst;
  logic [AW-1:0] head_idx;
  logic [AW-1:0] fill_idx;
  logic [AW-1:0] tail_idx;

  assign head_idx = head_q[AW-1:0];
  assign fill_idx = fill_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];

  assign count   = tail_q - head_q;
  assign pending = tail_q - fill_q;
  assign ready   = fill_q - head_q;

  // Slots still awaiting a response also count against capacity, so fetch
  // stays blocked until the discards drain.
  assign occupancy = {1'b0, count} + {1'b0, drop_cnt_q};
  assign allowin   = (occupancy < DEPTH_V);

  assign resp_drop     = inst_data_ok && (drop_cnt_q != '0);
  assign resp_fill     = inst_data_ok && (drop_cnt_q == '0) && (pending != '0);
  assign resp_consumed = resp_drop || resp_fill;

  // A hit forwards a response straight to decode when nothing filled is
  // waiting ahead of it.
  assign hit = (BYPASS != 0) && (ready == '0) && (pending != '0) &&
               (drop_cnt_q == '0) && inst_data_ok;

  assign valid_o = !cancel && ((ready != '0) || hit);
  assign pop     = valid_o && allowin_next;
  assign push    = req_fire && !cancel;

  // If a hit is popped in the same cycle, the data is never stored.
  assign store_inst = resp_fill && !cancel && !(hit && pop);

  assign pc_o    = (count == '0) ? '0 : pc_mem[head_idx];
  assign inst_o  = !valid_o ? '0 : (hit ? inst_rdata : inst_mem[head_idx]);
  assign count_o = count;

  // Next-state pointers and discard counter. Cancel takes priority over push,
  // fill and pop.
  always_comb begin
    head_d     = head_q;
    fill_d     = fill_q;
    tail_d     = tail_q;
    drop_cnt_d = drop_cnt_q;
    if (cancel) begin
      head_d     = '0;
      fill_d     = '0;
      tail_d     = '0;
      drop_cnt_d = drop_cnt_q + pending + PW'(req_fire) - PW'(resp_consumed);
    end else begin
      if (push)      tail_d     = tail_q + PW'(1);
      if (resp_fill) fill_d     = fill_q + PW'(1);
      if (resp_drop) drop_cnt_d = drop_cnt_q - PW'(1);
      if (pop)       head_d     = head_q + PW'(1);
    end
  end

  // Register the pointers and discard counter. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      fill_q     <= '0;
      tail_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      head_q     <= head_d;
      fill_q     <= fill_d;
      tail_q     <= tail_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage. Reset does not clear it, but it does block writes.
  always_ff @(posedge clk) begin
    if (!reset && push)       pc_mem[tail_idx]   <= req_pc;
    if (!reset && store_inst) inst_mem[fill_idx] <= inst_rdata;
  end

endmodule

// File: tb/tb_d_inst_queue.sv
// tb_d_inst_queue: directed vector table for d_inst_queue (DEPTH=4,
// BYPASS=1), followed by a hand-written wrap-around stream with an
// expected-pair queue.
module tb_d_inst_queue;

  logic        clk;
  logic        reset;
  logic        req_fire;
  logic [31:0] req_pc;
  logic        allowin;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        cancel;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        allowin_next;
  logic [2:0]  count_o;

  int n_vec;
  int n_err;

  d_inst_queue #(.DATA_W(32), .PC_W(32), .DEPTH(4), .BYPASS(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_fire     (req_fire),
    .req_pc       (req_pc),
    .allowin      (allowin),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .cancel       (cancel),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .inst_o       (inst_o),
    .allowin_next (allowin_next),
    .count_o      (count_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rf;
    logic [31:0] pc;
    logic        dok;
    logic [31:0] rd;
    logic        cxl;
    logic        ain;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_allowin;
    logic [2:0]  e_count;
    logic [2:0]  e_drop;
  } vec_t;

  vec_t vecs[$];

  // {pc, inst} pairs expected at decode, in order
  logic [63:0] exp_q[$];

  function automatic vec_t mk(input logic rst, input logic rf, input logic [31:0] pc,
                              input logic dok, input logic [31:0] rd, input logic cxl,
                              input logic ain, input logic ev, input logic [31:0] epc,
                              input logic [31:0] einst, input logic eain,
                              input logic [2:0] ecnt, input logic [2:0] edrop);
    vec_t v;
    v.rst = rst; v.rf = rf; v.pc = pc; v.dok = dok; v.rd = rd; v.cxl = cxl;
    v.ain = ain; v.e_valid = ev; v.e_pc = epc; v.e_inst = einst;
    v.e_allowin = eain; v.e_count = ecnt; v.e_drop = edrop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver: change inputs after the falling edge, then let combinational
  // outputs settle before sampling.
  task automatic drive(input logic rst, input logic rf, input logic [31:0] pc,
                       input logic dok, input logic [31:0] rd, input logic cxl,
                       input logic ain);
    @(negedge clk);
    reset        = rst;
    req_fire     = rf;
    req_pc       = pc;
    inst_data_ok = dok;
    inst_rdata   = rd;
    cancel       = cxl;
    allowin_next = ain;
    #1;
  endtask

  // One streaming cycle: drive, then score any pop against exp_q
  task automatic stream_step(input logic rf, input logic [31:0] pc, input logic dok,
                             input logic [31:0] rd, input logic ain);
    logic [63:0] e;
    drive(1'b0, rf, pc, dok, rd, 1'b0, ain);
    if (valid_o && allowin_next) begin
      if (exp_q.size() == 0) begin
        chk("stream extra pop", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("stream pc", pc_o, e[63:32]);
        chk("stream inst", inst_o, e[31:0]);
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] wpc;
    logic [31:0] wdat;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; req_fire = 1'b0; req_pc = '0; inst_data_ok = 1'b0;
    inst_rdata = '0; cancel = 1'b0; allowin_next = 1'b0;
    repeat (2) @(posedge clk);

    //                 rst rf pc            dok rdata         cxl ain  valid pc            inst          ain cnt drop
    // State just after reset
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Streaming with bypass
    vecs.push_back(mk(0, 1, 32'hbfc00000, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00000, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h24080001, 0, 1,   1, 32'hbfc00000, 32'h24080001, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Full and backpressure
    vecs.push_back(mk(0, 1, 32'hbfc00010, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00014, 0, 32'h0,        0, 0,   0, 32'hbfc00010, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00018, 0, 32'h0,        0, 0,   0, 32'hbfc00010, 32'h0,        1, 2, 0));
    vecs.push_back(mk(0, 1, 32'hbfc0001c, 0, 32'h0,        0, 0,   0, 32'hbfc00010, 32'h0,        1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00010, 32'h0,        0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h11111111, 0, 0,   1, 32'hbfc00010, 32'h11111111, 0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h22222222, 0, 0,   1, 32'hbfc00010, 32'h11111111, 0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h33333333, 0, 0,   1, 32'hbfc00010, 32'h11111111, 0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h44444444, 0, 0,   1, 32'hbfc00010, 32'h11111111, 0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'hbfc00010, 32'h11111111, 0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'hbfc00014, 32'h22222222, 1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'hbfc00018, 32'h33333333, 1, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 1,   1, 32'hbfc0001c, 32'h44444444, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Cancel with in-flight requests
    vecs.push_back(mk(0, 1, 32'hbfc00100, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00104, 0, 32'h0,        0, 0,   0, 32'hbfc00100, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00108, 0, 32'h0,        0, 0,   0, 32'hbfc00100, 32'h0,        1, 2, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'haaaa0001, 0, 0,   1, 32'hbfc00100, 32'haaaa0001, 1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0,   0, 32'hbfc00100, 32'h0,        1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 1, 32'hbfc00380, 1, 32'hdeadbeef, 0, 1,   0, 32'h0,        32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'hdeadbee2, 0, 1,   0, 32'hbfc00380, 32'h0,        1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h3c1d0380, 0, 1,   1, 32'hbfc00380, 32'h3c1d0380, 1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Cancel, push and response in one cycle
    vecs.push_back(mk(0, 1, 32'hbfc00200, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00204, 1, 32'h55555555, 1, 1,   0, 32'hbfc00200, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h66666666, 0, 1,   0, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Reset mid-operation: 2 entries queued, drop_cnt=1
    vecs.push_back(mk(0, 1, 32'hbfc00300, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0,   0, 32'hbfc00300, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00304, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 32'hbfc00308, 0, 32'h0,        0, 0,   0, 32'hbfc00304, 32'h0,        1, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'hbfc00304, 32'h0,        1, 2, 1));
    vecs.push_back(mk(1, 1, 32'hbfc0030c, 1, 32'h77777777, 0, 1,   0, 32'hbfc00304, 32'h0,        1, 2, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h88888888, 0, 1,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    // Draining discards with an empty queue keeps allowin low
    vecs.push_back(mk(0, 1, 32'hbfc00400, 0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00404, 0, 32'h0,        0, 0,   0, 32'hbfc00400, 32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 1, 32'hbfc00408, 0, 32'h0,        0, 0,   0, 32'hbfc00400, 32'h0,        1, 2, 0));
    vecs.push_back(mk(0, 1, 32'hbfc0040c, 0, 32'h0,        0, 0,   0, 32'hbfc00400, 32'h0,        1, 3, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        1, 0,   0, 32'hbfc00400, 32'h0,        0, 4, 0));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        0, 0, 4));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h99999991, 0, 1,   0, 32'h0,        32'h0,        0, 0, 4));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h99999992, 0, 1,   0, 32'h0,        32'h0,        1, 0, 3));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h99999993, 0, 1,   0, 32'h0,        32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 0, 32'h0,        1, 32'h99999994, 0, 1,   0, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 32'h0,        0, 0,   0, 32'h0,        32'h0,        1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.rf, v.pc, v.dok, v.rd, v.cxl, v.ain);
      chk($sformatf("v%0d valid_o", i), 32'(valid_o), 32'(v.e_valid));
      chk($sformatf("v%0d pc_o", i), pc_o, v.e_pc);
      chk($sformatf("v%0d inst_o", i), inst_o, v.e_inst);
      chk($sformatf("v%0d allowin", i), 32'(allowin), 32'(v.e_allowin));
      chk($sformatf("v%0d count_o", i), 32'(count_o), 32'(v.e_count));
      chk($sformatf("v%0d drop_cnt", i), 32'(dut.drop_cnt_q), 32'(v.e_drop));
    end

    // Wrap-around: 20 push/pop pairs with varied response delay and decode stalls
    for (int i = 0; i < 20; i++) begin
      wpc  = 32'hbfc01000 + 32'(i * 4);
      wdat = 32'h0a000000 ^ 32'(i * 32'h00010203);
      exp_q.push_back({wpc, wdat});
      stream_step(1'b1, wpc, 1'b0, 32'h0, 1'b1);
      for (int d = 0; d < (i % 3); d++) stream_step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      if ((i % 4) == 3) begin
        stream_step(1'b0, 32'h0, 1'b1, wdat, 1'b0);
        stream_step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      end else begin
        stream_step(1'b0, 32'h0, 1'b1, wdat, 1'b1);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("stream leftover", 32'(exp_q.size()), 32'(0));
    chk("stream end count_o", 32'(count_o), 32'(0));
    chk("stream end valid_o", 32'(valid_o), 32'(0));
    chk("stream end allowin", 32'(allowin), 32'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
